// File: rtl/irq_ctrl_if.sv
// CPU-facing interrupt handshake: request/ID/in-service from the controller,
// acknowledge and end-of-interrupt back from the CPU.
interface irq_ctrl_if #(
    parameter int NUM_SRC = 8
);
    // Width of the source ID; always derived from the source count.
    localparam int ID_W = $clog2(NUM_SRC);

    logic            irq_req;     // request pending for the CPU
    logic [ID_W-1:0] irq_id;      // source being requested or serviced
    logic            in_service;  // handler currently running
    logic            irq_ack;     // CPU accepts the current request
    logic            irq_eoi;     // CPU finished the handler

    // Controller side.
    modport master (
        output irq_req,
        output irq_id,
        output in_service,
        input  irq_ack,
        input  irq_eoi
    );

    // CPU side.
    modport slave (
        input  irq_req,
        input  irq_id,
        input  in_service,
        output irq_ack,
        output irq_eoi
    );
endinterface : irq_ctrl_if

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller.
// Captures rising edges of level interrupt lines into a pending register,
// qualifies them with a per-source enable mask and offers one request at a
// time to the CPU through a request / ack / end-of-interrupt handshake.
// Source 0 has the highest priority. All outputs come straight from flops.
module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask_en,
    input  logic [NUM_SRC-1:0] sw_clear,
    output logic [NUM_SRC-1:0] pending,
    irq_ctrl_if.master         cpu
);

    localparam int ID_W = $clog2(NUM_SRC);

    // Reject source counts outside the supported range at elaboration.
    if (NUM_SRC < 2 || NUM_SRC > 32) begin : g_bad_num_src
        $error("irq_ctrl: NUM_SRC must be in the range 2..32");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [NUM_SRC-1:0] src_q,        src_d;       // previous irq_src sample
    logic [NUM_SRC-1:0] mask_q,       mask_d;      // registered enable mask
    logic [NUM_SRC-1:0] pending_q,    pending_d;
    logic [ID_W-1:0]    irq_id_q,     irq_id_d;
    logic               irq_req_q,    irq_req_d;
    logic               in_service_q, in_service_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] rise;        // new rising edges this cycle
    logic [NUM_SRC-1:0] ack_clr;     // one-hot clear from an accepted request
    logic [NUM_SRC-1:0] eligible;    // pending and enabled
    logic               any_eligible;
    logic               cur_eligible; // the latched source is still eligible
    logic               ack_now;     // ack accepted in this cycle
    logic [ID_W-1:0]    winner;      // lowest eligible index

    // Lowest set index wins; scanning downward lets lower indices overwrite.
    function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_SRC-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    // Edge detection, eligibility and the winning source for this cycle.
    always_comb begin
        rise         = irq_src & ~src_q;
        // The mask is registered so that masking and sw_clear both take
        // effect on the request one edge after they are sampled.
        eligible     = pending_q & mask_q;
        any_eligible = |eligible;
        winner       = lowest_index(eligible);
        cur_eligible = eligible[irq_id_q];
        ack_now      = (state_q == REQ) && cpu.irq_ack;
    end

    // Pending register update: rise wins over any clear in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is inferred.
        ack_clr = '0;
        if (ack_now) begin
            ack_clr[irq_id_q] = 1'b1;
        end
        src_d     = irq_src;
        mask_d    = irq_mask_en;
        pending_d = (pending_q & ~(sw_clear | ack_clr)) | rise;
    end

    // Next-state and next-output logic of the request/service FSM.
    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        irq_req_d    = irq_req_q;
        in_service_d = in_service_q;

        unique case (state_q)
            IDLE: begin
                irq_req_d    = 1'b0;
                in_service_d = 1'b0;
                if (any_eligible) begin
                    // Latch the winner now; it is held until the next IDLE.
                    irq_id_d  = winner;
                    irq_req_d = 1'b1;
                    state_d   = REQ;
                end
            end

            REQ: begin
                // No preemption: irq_id stays put while the request is up.
                if (cpu.irq_ack) begin
                    // Ack beats a simultaneous withdraw.
                    irq_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end else if (!cur_eligible) begin
                    // Source was masked or cleared: withdraw the request.
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            SERVICE: begin
                // Pending keeps accumulating; nothing is offered until IDLE.
                irq_req_d = 1'b0;
                if (cpu.irq_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                irq_req_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // All state, with synchronous reset that also discards pending captures.
    always_ff @(posedge clk) begin
        // NOTE: nonblocking assignments so every flop sees pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= '0;
            mask_q       <= '0;
            pending_q    <= '0;
            irq_id_q     <= '0;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            irq_id_q     <= irq_id_d;
            irq_req_q    <= irq_req_d;
            in_service_q <= in_service_d;
        end
    end

    // Registered outputs only.
    assign pending        = pending_q;
    assign cpu.irq_req    = irq_req_q;
    assign cpu.irq_id     = irq_id_q;
    assign cpu.in_service = in_service_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    // Request and service phases are mutually exclusive.
    a_req_xor_service : assert property (
        @(posedge clk) disable iff (rst) !(irq_req_q && in_service_q));

    // The offered ID never changes while the request stays up.
    a_id_stable_in_req : assert property (
        @(posedge clk) disable iff (rst)
        (state_q == REQ && state_d == REQ) |=> $stable(irq_id_q));

    // The request output tracks the REQ state exactly.
    a_req_matches_state : assert property (
        @(posedge clk) disable iff (rst) irq_req_q == (state_q == REQ));

    // The service output tracks the SERVICE state exactly.
    a_service_matches_state : assert property (
        @(posedge clk) disable iff (rst) in_service_q == (state_q == SERVICE));

    // Any offered ID refers to an existing source.
    a_id_in_range : assert property (
        @(posedge clk) disable iff (rst) irq_req_q |-> (int'(irq_id_q) < NUM_SRC));

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (NUM_SRC = 8).
// Each scenario pushes the source IDs it expects to be requested; every
// rising edge of irq_req is popped against that queue as it appears.
module tb_irq_ctrl;

    localparam int NUM_SRC = 8;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic [7:0] irq_src     = '0;
    logic [7:0] irq_mask_en = '0;
    logic [7:0] sw_clear    = '0;
    logic [7:0] pending;

    irq_ctrl_if #(.NUM_SRC(NUM_SRC)) cpu_if ();

    irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .irq_mask_en (irq_mask_en),
        .sw_clear    (sw_clear),
        .pending     (pending),
        .cpu         (cpu_if)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         errors   = 0;
    logic [2:0] exp_q[$];
    logic       req_prev = 1'b0;

    // One clock; sample 1 time unit after the edge and score new requests.
    task automatic step();
        @(posedge clk);
        #1;
        if (cpu_if.irq_req === 1'b1 && !req_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: got request id %0d, required no request", cpu_if.irq_id);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (cpu_if.irq_id !== e) begin
                    errors++;
                    $display("FAIL req_id: got %0d required %0d", cpu_if.irq_id, e);
                end
            end
        end
        req_prev = (cpu_if.irq_req === 1'b1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", cpu_if.irq_req); end
        checks++; if (cpu_if.irq_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d required 0", cpu_if.irq_id); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h required 00", pending); end
        checks++; if (cpu_if.in_service !== 1'b0) begin errors++; $display("FAIL reset_in_service: got %b required 0", cpu_if.in_service); end
    endtask

    task automatic test_basic();
        irq_mask_en = 8'hFF;
        step();
        irq_src = 8'h08;
        step();
        irq_src = 8'h00;
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL basic_pending: got %h required 08", pending); end
        checks++; if (cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b required 0", cpu_if.irq_req); end
        exp_q.push_back(3'd3);
        step();
        checks++; if (cpu_if.irq_req !== 1'b1 || cpu_if.irq_id !== 3'd3) begin errors++; $display("FAIL basic_req: got req %b id %0d required req 1 id 3", cpu_if.irq_req, cpu_if.irq_id); end
        steps(2);
        checks++; if (cpu_if.irq_req !== 1'b1) begin errors++; $display("FAIL basic_req_held: got %b required 1", cpu_if.irq_req); end
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        checks++; if (cpu_if.irq_req !== 1'b0 || cpu_if.in_service !== 1'b1) begin errors++; $display("FAIL basic_ack: got req %b in_service %b required req 0 in_service 1", cpu_if.irq_req, cpu_if.in_service); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL basic_ack_pending: got %h required 00", pending); end
        steps(2);
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        checks++; if (cpu_if.in_service !== 1'b0) begin errors++; $display("FAIL basic_eoi: got in_service %b required 0", cpu_if.in_service); end
        step();
        checks++; if (cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL basic_idle_req: got %b required 0", cpu_if.irq_req); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_priority();
        irq_src = 8'h24;
        step();
        irq_src = 8'h00;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd5);
        step();
        checks++; if (cpu_if.irq_id !== 3'd2) begin errors++; $display("FAIL prio_first: got %0d required 2", cpu_if.irq_id); end
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        checks++; if (pending !== 8'h20) begin errors++; $display("FAIL prio_pending: got %h required 20", pending); end
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        checks++; if (cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL prio_rearm_early: got %b required 0", cpu_if.irq_req); end
        step();
        checks++; if (cpu_if.irq_req !== 1'b1 || cpu_if.irq_id !== 3'd5) begin errors++; $display("FAIL prio_second: got req %b id %0d required req 1 id 5", cpu_if.irq_req, cpu_if.irq_id); end
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL prio_missing: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_no_preempt();
        irq_src = 8'h10;
        step();
        irq_src = 8'h00;
        exp_q.push_back(3'd4);
        step();
        irq_src = 8'h01;
        step();
        irq_src = 8'h00;
        checks++; if (pending !== 8'h11 || cpu_if.irq_id !== 3'd4) begin errors++; $display("FAIL nopre_arrival: got pending %h id %0d required pending 11 id 4", pending, cpu_if.irq_id); end
        step();
        checks++; if (cpu_if.irq_req !== 1'b1 || cpu_if.irq_id !== 3'd4) begin errors++; $display("FAIL nopre_held: got req %b id %0d required req 1 id 4", cpu_if.irq_req, cpu_if.irq_id); end
        exp_q.push_back(3'd0);
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        checks++; if (cpu_if.in_service !== 1'b1 || cpu_if.irq_id !== 3'd4) begin errors++; $display("FAIL nopre_service: got in_service %b id %0d required 1 and 4", cpu_if.in_service, cpu_if.irq_id); end
        steps(3);
        checks++; if (cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL nopre_service_req: got %b required 0", cpu_if.irq_req); end
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        step();
        checks++; if (cpu_if.irq_req !== 1'b1 || cpu_if.irq_id !== 3'd0) begin errors++; $display("FAIL nopre_next: got req %b id %0d required req 1 id 0", cpu_if.irq_req, cpu_if.irq_id); end
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nopre_missing: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_mask_withdraw();
        irq_mask_en = 8'hBF;
        step();
        irq_src = 8'h40;
        step();
        irq_src = 8'h00;
        steps(4);
        checks++; if (cpu_if.irq_req !== 1'b0 || pending !== 8'h40) begin errors++; $display("FAIL mask_blocked: got req %b pending %h required req 0 pending 40", cpu_if.irq_req, pending); end
        irq_mask_en = 8'hFF;
        exp_q.push_back(3'd6);
        step();
        checks++; if (cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL mask_set_early: got %b required 0", cpu_if.irq_req); end
        step();
        checks++; if (cpu_if.irq_req !== 1'b1 || cpu_if.irq_id !== 3'd6) begin errors++; $display("FAIL mask_set_req: got req %b id %0d required req 1 id 6", cpu_if.irq_req, cpu_if.irq_id); end
        irq_mask_en = 8'hBF;
        step();
        checks++; if (cpu_if.irq_req !== 1'b1) begin errors++; $display("FAIL mask_clr_early: got %b required 1", cpu_if.irq_req); end
        step();
        checks++; if (cpu_if.irq_req !== 1'b0 || pending !== 8'h40) begin errors++; $display("FAIL mask_withdraw: got req %b pending %h required req 0 pending 40", cpu_if.irq_req, pending); end
        sw_clear = 8'h40;
        step();
        sw_clear = 8'h00;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL sw_clear: got %h required 00", pending); end
        irq_mask_en = 8'hFF;
        step();
        // Withdraw through sw_clear instead of the mask.
        irq_src = 8'h02;
        step();
        irq_src = 8'h00;
        exp_q.push_back(3'd1);
        step();
        sw_clear = 8'h02;
        step();
        sw_clear = 8'h00;
        checks++; if (cpu_if.irq_req !== 1'b1) begin errors++; $display("FAIL clr_withdraw_early: got %b required 1", cpu_if.irq_req); end
        step();
        checks++; if (cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL clr_withdraw: got %b required 0", cpu_if.irq_req); end
        steps(2);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mask_missing: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_set_wins();
        irq_mask_en = 8'hFD;
        step();
        irq_src = 8'h02;
        step();
        irq_src = 8'h00;
        step();
        irq_src  = 8'h02;
        sw_clear = 8'h02;
        step();
        irq_src  = 8'h00;
        sw_clear = 8'h00;
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL set_wins_clear: got %h required 02", pending); end
        sw_clear = 8'h02;
        step();
        sw_clear = 8'h00;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL plain_clear: got %h required 00", pending); end
        // A new edge on the acknowledged source survives the ack clear.
        irq_mask_en = 8'hFF;
        step();
        irq_src = 8'h02;
        step();
        irq_src = 8'h00;
        exp_q.push_back(3'd1);
        step();
        irq_src        = 8'h02;
        cpu_if.irq_ack = 1'b1;
        step();
        irq_src        = 8'h00;
        cpu_if.irq_ack = 1'b0;
        checks++; if (pending !== 8'h02 || cpu_if.in_service !== 1'b1) begin errors++; $display("FAIL set_wins_ack: got pending %h in_service %b required 02 and 1", pending, cpu_if.in_service); end
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        exp_q.push_back(3'd1);
        step();
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL set_wins_reack: got %h required 00", pending); end
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL set_wins_missing: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_level();
        irq_src = 8'h80;
        exp_q.push_back(3'd7);
        steps(2);
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        steps(3);
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        steps(43);
        checks++; if (pending !== 8'h00 || cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL level_once: got pending %h req %b required 00 and 0", pending, cpu_if.irq_req); end
        irq_src = 8'h00;
        steps(3);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL level_missing: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_service();
        irq_src = 8'h04;
        step();
        exp_q.push_back(3'd2);
        step();
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        irq_src = 8'h00;
        step();
        irq_src = 8'h0C;
        step();
        irq_src = 8'h04;
        checks++; if (pending !== 8'h0C || cpu_if.in_service !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: got pending %h in_service %b required 0c and 1", pending, cpu_if.in_service); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (cpu_if.irq_req !== 1'b0 || cpu_if.irq_id !== 3'd0 || pending !== 8'h00 || cpu_if.in_service !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got req %b id %0d pending %h in_service %b required all 0", cpu_if.irq_req, cpu_if.irq_id, pending, cpu_if.in_service);
        end
        step();
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL rst_mid_reedge: got %h required 04", pending); end
        exp_q.push_back(3'd2);
        step();
        checks++; if (cpu_if.irq_req !== 1'b1 || cpu_if.irq_id !== 3'd2) begin errors++; $display("FAIL rst_mid_req: got req %b id %0d required req 1 id 2", cpu_if.irq_req, cpu_if.irq_id); end
        cpu_if.irq_ack = 1'b1;
        step();
        cpu_if.irq_ack = 1'b0;
        cpu_if.irq_eoi = 1'b1;
        step();
        cpu_if.irq_eoi = 1'b0;
        irq_src = 8'h00;
        steps(3);
        checks++; if (pending !== 8'h00 || cpu_if.irq_req !== 1'b0) begin errors++; $display("FAIL rst_mid_lost: got pending %h req %b required 00 and 0", pending, cpu_if.irq_req); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_mid_missing: got %0d outstanding required 0", exp_q.size()); end
    endtask

    initial begin
        cpu_if.irq_ack = 1'b0;
        cpu_if.irq_eoi = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_no_preempt();
        test_mask_withdraw();
        test_set_wins();
        test_level();
        test_reset_mid_service();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_irq_ctrl

// File: doc/irq_ctrl.md
# irq_ctrl

Fixed-priority interrupt controller that sits directly downstream of the timer and the other peripheral IPs. It collects their level interrupt lines (the timer's `timer_irq` lands on one source input), captures rising edges into a pending register, and applies a per-source enable mask. It presents one request at a time to the CPU through a request/acknowledge/end-of-interrupt handshake.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources; legal range 2–32.
- `ID_W`, default `$clog2(NUM_SRC)`: width of the source ID. Derived; never overridden.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `irq_src` input, `NUM_SRC` bits: raw interrupt lines from the IPs; bit i is source i.
- `irq_mask_en` input, `NUM_SRC` bits: 1 = source eligible for request; masking never blocks capture.
- `sw_clear` input, `NUM_SRC` bits: one-cycle pulses that clear `pending[i]`.
- `irq_ack` input, 1 bit: CPU accepts the current request.
- `irq_eoi` input, 1 bit: CPU finished the handler.
- `irq_req` output, 1 bit: request to the CPU.
- `irq_id` output, `ID_W` bits: ID of the requested or in-service source.
- `pending` output, `NUM_SRC` bits: captured, unserviced interrupts.
- `in_service` output, 1 bit: the handler is active.

## Operation
- **Edge capture:** `src_q` registers `irq_src`; `rise = irq_src & ~src_q`.
- **Pending update:**
  - `pending[i]` is set on `rise[i]`.
  - `pending[i]` is cleared by `sw_clear[i]`, or by the ack of source i.
  - If set and clear occur in the same cycle, set wins: `pending[i]` ends at 1.
- **Eligibility:** `eligible = pending & irq_mask_en`. The winner is the lowest set index (source 0 is highest priority).
- **FSM states:** IDLE, REQ, SERVICE.
- **IDLE:**
  - `irq_req` = 0, `in_service` = 0.
  - If `eligible` is nonzero: latch the winner into `irq_id`, go to REQ.
- **REQ:**
  - `irq_req` = 1; `irq_id` is held stable, with no preemption by higher-priority arrivals.
  - `irq_ack` = 1: clear `pending[irq_id]` (set-wins rule applies), go to SERVICE.
  - Otherwise, if `eligible[irq_id]` drops (masked or `sw_clear`): withdraw and go to IDLE; `irq_req` falls the next cycle.
  - If ack and the drop occur in the same cycle, ack wins.
- **SERVICE:**
  - `irq_req` = 0, `in_service` = 1, `irq_id` held.
  - `irq_eoi` = 1: go to IDLE.
  - Pending sources keep accumulating; no new request is issued until IDLE.
- **Ignored inputs:**
  - `irq_ack` outside REQ.
  - `irq_eoi` outside SERVICE.
- **Level sources:** a source held high, such as the timer before `timer_clear`, produces only one edge and therefore one pending capture.

## Timing
- **Reset values** (synchronous `rst` = 1 forces all of these at the next edge):
  - `irq_req` = 0, `irq_id` = 0, `pending` = 0, `in_service` = 0.
  - FSM = IDLE, `src_q` = 0.
- **Reset mid-operation:** drops any request or service in progress and discards pending.
- **Post-reset edge:** a line held high through reset is seen as a new edge on the first cycle after `rst` deasserts.
- **Request latency:** `irq_src[i]` first sampled high at edge t gives `pending[i]` = 1 after t and `irq_req` = 1 after t+1 (2 cycles, IDLE, mask set).
- **Ack:** `irq_ack` sampled at edge t gives `irq_req` = 0 and `in_service` = 1 after t; `pending[irq_id]` is cleared after t.
- **Re-arm:** `irq_eoi` sampled at edge t gives `in_service` = 0 after t. The next `irq_req` is no earlier than after t+1.
- **Withdraw:** a mask or clear at edge t gives `irq_req` = 0 after t+1.
- **Registered outputs:** all outputs are registered; no combinational input-to-output path.

## Test plan
- **Basic request, NUM_SRC=8:**
  - Stimulus: reset; mask `8'hFF`; pulse `irq_src[3]` at edge 10.
  - Required: `pending` = `8'h08` after edge 10; `irq_req` = 1 with `irq_id` = 3 after edge 11; ack at edge 14 gives `pending` = 0 and `in_service` = 1; eoi gives IDLE with `irq_req` staying 0.
- **Priority, simultaneous edges:**
  - Stimulus: edges on sources 5 and 2 in the same cycle.
  - Required: first request `irq_id` = 2; after ack and eoi, `irq_id` = 5, issued 2 edges after eoi.
- **No preemption:**
  - Stimulus: while REQ for source 4, edge on source 0.
  - Required: `irq_id` stays 4 until ack; source 0 is requested only after eoi.
- **Mask and withdraw:**
  - Stimulus: source 6 pending with its mask bit 0.
  - Required: no `irq_req`. Setting the mask gives `irq_req` 1 edge later. Clearing the mask during REQ gives `irq_req` low 1 edge later, with `pending[6]` still 1.
- **Set-wins and level source:**
  - Stimulus: `sw_clear[1]` in the same cycle as a new `rise[1]`; separately, hold `irq_src[7]` high for 50 cycles.
  - Required: `pending[1]` stays 1; source 7 is serviced exactly once.
- **Reset mid-service:**
  - Stimulus: assert `rst` for 1 cycle during SERVICE with sources 2 and 3 pending and `irq_src[2]` held high.
  - Required: all outputs are 0 after the reset edge; `pending[2]` re-sets on the first post-reset cycle; source 3 is lost.
